// File: rtl/prescaled_mode_counter_pkg.sv
// Shared types for the prescaled mode counter: counting modes and the
// decision made on each counting step.
package prescaled_mode_counter_pkg;

  localparam logic [1:0] MODE_WRAP    = 2'd0;
  localparam logic [1:0] MODE_SAT     = 2'd1;
  localparam logic [1:0] MODE_ONESHOT = 2'd2;

  typedef enum logic [1:0] {
    MODE_T_WRAP    = 2'd0,
    MODE_T_SAT     = 2'd1,
    MODE_T_ONESHOT = 2'd2
  } mode_t;

  // What a step does: plain +/-1, wrap to the opposite end, hold (SAT),
  // or hold and halt (ONESHOT).
  typedef enum logic [1:0] {
    ACT_STEP = 2'd0,
    ACT_WRAP = 2'd1,
    ACT_HOLD = 2'd2,
    ACT_HALT = 2'd3
  } act_t;

  // Reserved mode encoding 2'b11 falls through to WRAP.
  function automatic act_t step_action(input logic [1:0] mode, input logic terminal);
    if (!terminal) return ACT_STEP;
    case (mode)
      MODE_SAT:     return ACT_HOLD;
      MODE_ONESHOT: return ACT_HALT;
      default:      return ACT_WRAP;
    endcase
  endfunction

endpackage

// File: rtl/prescaled_mode_counter_if.sv
// Control/status bundle of the prescaled mode counter.
// Optional capture signals are present when COUNTER_CAPTURE_EN is defined.
interface prescaled_mode_counter_if #(
  parameter int WIDTH   = 32,
  parameter int PRESC_W = 8,
  parameter int Q_W     = 8
);
  logic               clr;
  logic               en;
  logic               load;
  logic [WIDTH-1:0]   load_val;
  logic               dir;
  logic [1:0]         mode;
  logic [PRESC_W-1:0] presc_div;
  logic [WIDTH-1:0]   max_val;
  logic [WIDTH-1:0]   cmp_val;
  logic [WIDTH-1:0]   cnt;
  logic [Q_W-1:0]     q;
  logic               tick;
  logic               cnt_max;
  logic               at_zero;
  logic               cmp_match;
  logic               ovf;
  logic               done;
`ifdef COUNTER_CAPTURE_EN
  logic               capture;
  logic [WIDTH-1:0]   cap_val;
  logic               cap_valid;
`endif

  modport master (
    output clr, en, load, load_val, dir, mode, presc_div, max_val, cmp_val,
`ifdef COUNTER_CAPTURE_EN
    output capture,
    input  cap_val, cap_valid,
`endif
    input  cnt, q, tick, cnt_max, at_zero, cmp_match, ovf, done
  );

  modport slave (
    input  clr, en, load, load_val, dir, mode, presc_div, max_val, cmp_val,
`ifdef COUNTER_CAPTURE_EN
    input  capture,
    output cap_val, cap_valid,
`endif
    output cnt, q, tick, cnt_max, at_zero, cmp_match, ovf, done
  );
endinterface

// File: rtl/prescaled_mode_counter_prescaler.sv
// Enable-gated prescaler: tick every div_i+1 enabled cycles.
module prescaled_mode_counter_prescaler #(
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en_i,
  input  logic               clr_i,
  input  logic [PRESC_W-1:0] div_i,
  output logic               tick_o
);
  logic [PRESC_W-1:0] pcnt_q, pcnt_d;

  assign tick_o = en_i & (pcnt_q == div_i);

  // Next prescale count: clear wins, en low freezes, restart on tick.
  always_comb begin
    pcnt_d = pcnt_q;
    if (clr_i)     pcnt_d = '0;
    else if (en_i) pcnt_d = tick_o ? '0 : pcnt_q + PRESC_W'(1);
  end

  // Prescale count register.
  always_ff @(posedge clk) begin
    if (rst) pcnt_q <= '0;
    else     pcnt_q <= pcnt_d;
  end
endmodule

// File: rtl/prescaled_mode_counter.sv
// Up/down event counter with prescaler, terminal value, WRAP/SAT/ONESHOT
// modes, compare-match pulse and sticky overflow.
// Optional feature macro: COUNTER_CAPTURE_EN (snapshot register on capture).
module prescaled_mode_counter
  import prescaled_mode_counter_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int PRESC_W = 8,
  parameter int Q_W     = 8
) (
  input logic                    clk,
  input logic                    rst,
  prescaled_mode_counter_if.slave bus
);
  logic [WIDTH-1:0] cnt_q, cnt_d, nxt;
  logic             ovf_q, ovf_d, done_q, done_d, cmp_q, cmp_d;
  logic             tick, step, terminal, held;
  act_t             act;

  // load restarts the prescale period as well as clr
  prescaled_mode_counter_prescaler #(.PRESC_W(PRESC_W)) u_presc (
    .clk    (clk),
    .rst    (rst),
    .en_i   (bus.en),
    .clr_i  (bus.clr | bus.load),
    .div_i  (bus.presc_div),
    .tick_o (tick)
  );

  assign step     = tick & ~done_q;
  assign terminal = bus.dir ? (cnt_q >= bus.max_val) : (cnt_q == '0);
  assign act      = step_action(bus.mode, terminal);
  assign held     = (act == ACT_HOLD) || (act == ACT_HALT);

  // Candidate value for a step; SAT-up clamps an out-of-range load to max_val.
  always_comb begin
    nxt = cnt_q;
    case (act)
      ACT_STEP: nxt = bus.dir ? cnt_q + WIDTH'(1) : cnt_q - WIDTH'(1);
      ACT_WRAP: nxt = bus.dir ? '0 : bus.max_val;
      ACT_HOLD: nxt = bus.dir ? bus.max_val : '0;
      default:  nxt = cnt_q;
    endcase
  end

  // Next state with priority clr > load > step.
  always_comb begin
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    done_d = done_q;
    cmp_d  = 1'b0;
    if (bus.clr) begin
      cnt_d  = '0;
      ovf_d  = 1'b0;
      done_d = 1'b0;
    end else if (bus.load) begin
      cnt_d  = bus.load_val;
      done_d = 1'b0;
    end else if (step) begin
      cnt_d  = nxt;
      ovf_d  = ovf_q | terminal;
      done_d = (act == ACT_HALT);
      // a hold that leaves the value unchanged must not re-pulse
      cmp_d  = (nxt == bus.cmp_val) && !(held && (nxt == cnt_q));
    end
  end

  // Counter state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      done_q <= 1'b0;
      cmp_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      done_q <= done_d;
      cmp_q  <= cmp_d;
    end
  end

  assign bus.cnt       = cnt_q;
  assign bus.q         = cnt_q[WIDTH-1 -: Q_W];
  assign bus.tick      = tick;
  assign bus.cnt_max   = (cnt_q == bus.max_val);
  assign bus.at_zero   = (cnt_q == '0);
  assign bus.cmp_match = cmp_q;
  assign bus.ovf       = ovf_q;
  assign bus.done      = done_q;

`ifdef COUNTER_CAPTURE_EN
  logic [WIDTH-1:0] cap_val_q;
  logic             cap_valid_q;

  // Snapshot the pre-update count; independent of en/done.
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_val_q   <= '0;
      cap_valid_q <= 1'b0;
    end else begin
      cap_valid_q <= bus.capture;
      if (bus.capture) cap_val_q <= cnt_q;
    end
  end

  assign bus.cap_val   = cap_val_q;
  assign bus.cap_valid = cap_valid_q;
`endif
endmodule
